// File: rtl/mfp_usart_tx.sv
// MFP68901 USART transmitter: UDR buffer, shifter FSM, TSR status and interrupt pulses.
// Bit timing is driven by TC_RISE strobes from timer D.
module mfp_usart_tx #(
  parameter int DIV16_TICKS = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TC_RISE,
  input  logic [7:0] UCR_I,
  input  logic       UDR_WE,
  input  logic [7:0] UDR_I,
  input  logic       TSR_WE,
  input  logic       TSR_RD,
  input  logic [7:0] TSR_I,
  output logic [7:0] TSR_O,
  output logic       SO,
  output logic       IRQ_BE,
  output logic       IRQ_ERR
);
  localparam int TW = $clog2(2*DIV16_TICKS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        r_state;
  logic [TW-1:0] r_tick;
  logic [TW-1:0] r_stop_len;
  logic [3:0]    r_wlen;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_buf, r_data, r_shift;
  logic          r_div16, r_par_en, r_par_even;
  logic          r_te, r_b, r_be, r_ue, r_end, r_pend;
  logic          r_so, r_irq_be, r_irq_err;

  logic          w_fmt_ok, w_bound, w_load_idle, w_load_stop, w_load;
  logic          w_ue_set, w_end_set, w_end_clr, w_parity, w_unused;
  logic [TW-1:0] w_len, w_bit_len, w_stop_new;
  logic [7:0]    w_mask;

  assign w_unused   = UCR_I[0];
  assign w_fmt_ok   = (UCR_I[4:3] != 2'b00);
  assign w_mask     = 8'hFF >> UCR_I[6:5];
  assign w_bit_len  = r_div16 ? TW'(DIV16_TICKS) : TW'(1);
  assign w_len      = (r_state == STOP) ? r_stop_len : w_bit_len;
  assign w_bound    = TC_RISE && (r_state != IDLE) && (r_tick + TW'(1) == w_len);
  assign w_parity   = (^r_data) ^ ~r_par_even;

  always_comb begin
    w_stop_new = TW'(1);
    case (UCR_I[4:3])
      2'b01:   w_stop_new = UCR_I[7] ? TW'(DIV16_TICKS)       : TW'(1);
      2'b10:   w_stop_new = UCR_I[7] ? TW'(DIV16_TICKS*3/2)   : TW'(2);
      2'b11:   w_stop_new = UCR_I[7] ? TW'(2*DIV16_TICKS)     : TW'(2);
      default: w_stop_new = TW'(1);
    endcase
  end

  // Loads happen either from idle on any strobe, or back-to-back at the stop boundary.
  assign w_load_idle = (r_state == IDLE) && TC_RISE && r_te && !r_b && !r_be && w_fmt_ok;
  assign w_load_stop = (r_state == STOP) && w_bound && r_te && !r_be && w_fmt_ok;
  assign w_load      = w_load_idle || w_load_stop;
  assign w_ue_set    = (r_state == STOP) && w_bound && r_te && r_be;
  assign w_end_set   = ((r_state == STOP) && w_bound && !r_te) ||
                       ((r_state == IDLE) && TSR_WE && !TSR_I[0] && r_te);
  assign w_end_clr   = TSR_WE && TSR_I[0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_tick     <= '0;
      r_stop_len <= TW'(1);
      r_wlen     <= 4'd8;
      r_bitcnt   <= '0;
      r_buf      <= '0;
      r_data     <= '0;
      r_shift    <= '0;
      r_div16    <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_even <= 1'b0;
      r_te       <= 1'b0;
      r_b        <= 1'b0;
      r_be       <= 1'b1;
      r_ue       <= 1'b0;
      r_end      <= 1'b0;
      r_pend     <= 1'b0;
      r_so       <= 1'b1;
      r_irq_be   <= 1'b0;
      r_irq_err  <= 1'b0;
    end else begin
      r_irq_be  <= w_load;
      r_irq_err <= w_ue_set;

      // A write colliding with a transfer is kept; BE drops one cycle later.
      if (r_pend) begin
        r_be   <= 1'b0;
        r_pend <= 1'b0;
        if (UDR_WE) r_buf <= UDR_I;
      end else if (UDR_WE && w_load) begin
        r_buf  <= UDR_I;
        r_be   <= 1'b1;
        r_pend <= 1'b1;
      end else if (UDR_WE) begin
        r_buf <= UDR_I;
        r_be  <= 1'b0;
      end else if (w_load) begin
        r_be <= 1'b1;
      end

      if (TSR_WE) begin
        r_te <= TSR_I[0];
        r_b  <= TSR_I[3];
      end

      if (w_ue_set)    r_ue <= 1'b1;
      else if (TSR_RD) r_ue <= 1'b0;

      if (w_end_clr)      r_end <= 1'b0;
      else if (w_end_set) r_end <= 1'b1;

      if (r_state == IDLE)  r_tick <= '0;
      else if (TC_RISE)     r_tick <= w_bound ? '0 : r_tick + TW'(1);

      if (w_load) begin
        r_state    <= START;
        r_so       <= 1'b0;
        r_tick     <= '0;
        r_div16    <= UCR_I[7];
        r_wlen     <= 4'd8 - {2'b00, UCR_I[6:5]};
        r_stop_len <= w_stop_new;
        r_par_en   <= UCR_I[2];
        r_par_even <= UCR_I[1];
        r_data     <= r_buf & w_mask;
        r_shift    <= r_buf & w_mask;
      end else if (w_bound) begin
        case (r_state)
          START: begin
            r_state  <= DATA;
            r_so     <= r_shift[0];
            r_bitcnt <= '0;
          end
          DATA: begin
            if ({1'b0, r_bitcnt} == r_wlen - 4'd1) begin
              r_state <= r_par_en ? PARITY : STOP;
              r_so    <= r_par_en ? w_parity : 1'b1;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
              r_shift  <= r_shift >> 1;
              r_so     <= r_shift[1];
            end
          end
          PARITY: begin
            r_state <= STOP;
            r_so    <= 1'b1;
          end
          STOP: begin
            r_state <= IDLE;
            r_so    <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Idle line follows TE/B directly so break takes effect as soon as the shifter is idle.
  assign SO      = (r_state == IDLE) ? ~(r_b & r_te) : r_so;
  assign TSR_O   = {r_be, r_ue, 1'b0, r_end, r_b, 2'b00, r_te};
  assign IRQ_BE  = r_irq_be;
  assign IRQ_ERR = r_irq_err;
endmodule

// File: doc/mfp_usart_tx.md
Name: mfp_usart_tx

Overview:
- Transmit half of the MFP68901 USART.
- Serializes bytes written to UDR onto the serial output SO.
- Bit clock is timer D's output, delivered as a one-cycle strobe on each rising edge of the timer output.
- Sits beside the MFP timers inside the MFP top level and raises the transmit-buffer-empty and transmit-error interrupt requests.

Parameters:
- DIV16_TICKS, 16, number of TC_RISE strobes per bit when UCR[7]=1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- TC_RISE  in  1  one-CLK strobe at each rising edge of the transmit clock (timer D output).
- UCR_I  in  8  USART control register value. Held stable by the MFP top, which owns the register.
- UDR_WE  in  1  strobe: write transmit data buffer.
- UDR_I  in  8  transmit data.
- TSR_WE  in  1  strobe: write TSR.
- TSR_RD  in  1  strobe: TSR read completed. Clears sticky flags.
- TSR_I  in  8  TSR write data. Bit0 = TE (transmit enable), bit3 = B (break).
- TSR_O  out  8  TSR read data: {BE, UE, 1'b0, END, B, 2'b00, TE}.
- SO  out  1  serial output.
- IRQ_BE  out  1  one-CLK pulse when the buffer transfers to the shifter.
- IRQ_ERR  out  1  one-CLK pulse on underrun.

Behaviour:
- Reset state:
  - SO=1, TE=0, B=0, BE=1, UE=0, END=0, IRQ_BE=0, IRQ_ERR=0.
  - State IDLE, tick counter 0.
- UCR decode:
  - [7] clock mode: 1 = /16 (DIV16_TICKS strobes per bit), 0 = /1 (one strobe per bit).
  - [6:5] word length: 00=8, 01=7, 10=6, 11=5 bits.
  - [4:3] stop format: 00 = synchronous (treated as disabled; shifter stays IDLE), 01 = 1 stop, 10 = 1.5 stop, 11 = 2 stop.
  - 1.5 stop lasts 24 ticks in /16 mode and 2 bits in /1 mode.
  - [2] parity enable; [1] 1 = even, 0 = odd.
- Bit timing:
  - The tick counter advances only on TC_RISE.
  - A "bit boundary" is the TC_RISE on which the counter reaches the bit length; the counter returns to 0 there.
  - In /1 mode every TC_RISE is a bit boundary.
  - The counter holds 0 in IDLE.
- Buffer:
  - UDR_WE stores UDR_I and clears BE, in the same cycle.
  - A write while BE=0 overwrites the buffer silently.
- State machine:
  - IDLE:
    - SO = 0 if B=1 && TE=1, else SO = 1.
    - On TC_RISE with TE=1, B=0, BE=0 and a valid format: load the shifter with the low word-length bits of the buffer, set BE, pulse IRQ_BE, go to START.
  - START: SO=0 for one bit time, then DATA.
  - DATA:
    - Shift out LSB first for word-length bits.
    - Next state is PARITY if parity is enabled, else STOP.
  - PARITY: SO = XOR of data bits, inverted when even=0 (odd parity), for one bit time.
  - STOP:
    - SO=1 for the stop length.
    - At the end, if BE=0 and TE=1: load the next byte at this same boundary, pulse IRQ_BE, enter START directly (back-to-back, no idle bit).
    - Else if TE=1 and BE=1: set UE, pulse IRQ_ERR, go to IDLE.
    - Else (TE=0): set END, go to IDLE.
- TE cleared mid-character: the current character completes, including its stop bits; then END is set.
- TE=0 in IDLE: END=1 and SO=1.
- TSR write:
  - Updates TE and B.
  - Setting TE clears END.
  - Setting B takes effect only once the shifter is IDLE; the character in flight finishes first.
- TSR_RD clears UE. If UE would be set in the same cycle, set wins.
- UCR changes take effect at the next character load. The character in flight uses latched format fields.
- RST mid-character: immediate return to reset state, with SO=1 on the next cycle.
- Simultaneous UDR_WE and transfer in the same cycle: the transfer uses the old buffer and BE ends 1. The new byte is not lost; it is held in the buffer and BE is cleared one cycle later.

Test Plan:
- UCR=0x88 (/16, 8N1), TE=1, UDR=0x55 → SO: start 0, then 1,0,1,0,1,0,1,0, stop 1. Each bit is 16 TC_RISE. IRQ_BE pulses once at load. BE=1 after load.
- UCR=0x0E (/1, 8 bits, 1 stop, even parity), UDR=0x07 → parity bit 1. Same with UCR=0x0C (odd) → parity 0. 11 bit times total.
- Back-to-back: UDR=0xA5, then UDR=0x3C written during DATA → second start bit immediately follows the first stop bit. Two IRQ_BE pulses, UE stays 0. After the second stop, UE=1 and IRQ_ERR pulses. TSR_RD clears UE.
- UCR=0xF0 (/16, 5 bits, 1.5 stop), UDR=0xFF → 5 data ones, stop held 24 TC_RISE. UCR[4:3]=00 → no transmission, SO stays 1.
- Clear TE during bit 3 → character completes, then END=1, SO=1, no IRQ_ERR.
- Set B during a character → SO goes low only after the stop bits. Clearing B returns SO=1.
- Assert RST during DATA → next cycle SO=1, BE=1, TSR_O=0x80.
